// File: rtl/dma_addr_sequencer.sv
// DMA address / word-count sequencer (Am2940 style).
// Holds the address counter, the word counter and their reload registers.
// Decodes one 3-bit instruction per clock, steps both counters on enabled
// transfers and flags transfer completion according to the selected mode.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | counters loaded or re-initialised, no step taken yet
// RUN   | at least one step taken, terminal condition not reached
// STOP  | terminal condition reached; counting inhibited (modes 00-10)

module dma_addr_sequencer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic [2:0]    instr,
  input  logic [AW-1:0] data_in,
  input  logic          cnt_en,
  output logic [AW-1:0] data_out,
  output logic          data_oe,
  output logic [AW-1:0] addr_out,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [2:0] I_WCR    = 3'd0;
  localparam logic [2:0] I_RCR    = 3'd1;
  localparam logic [2:0] I_RWC    = 3'd2;
  localparam logic [2:0] I_RAC    = 3'd3;
  localparam logic [2:0] I_REINIT = 3'd4;
  localparam logic [2:0] I_LDA    = 3'd5;
  localparam logic [2:0] I_LDW    = 3'd6;
  localparam logic [2:0] I_ENC    = 3'd7;

  localparam logic [1:0] MODE_WCZ  = 2'b00;
  localparam logic [1:0] MODE_WCMP = 2'b01;
  localparam logic [1:0] MODE_ACMP = 2'b10;
  localparam logic [1:0] MODE_WRAP = 2'b11;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]    ctrl;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] word_reg;
  logic [AW-1:0] word_cnt;
  state_t        state;
  state_t        state_nxt;
  logic          wrap_pulse;

  logic [1:0]    mode;
  logic          dir_dec;
  logic          step;
  logic          terminal;
  logic [AW-1:0] addr_step;
  logic [AW-1:0] word_step;

  assign mode    = ctrl[1:0];
  assign dir_dec = ctrl[2];

  // A count step happens only on ENC with the strobe high and not stopped.
  assign step = (instr == I_ENC) && cnt_en && (state != ST_STOP);

  // Post-step counter values and the terminal condition evaluated on them.
  always_comb begin
    addr_step = dir_dec ? (addr_cnt - ONE) : (addr_cnt + ONE);
    word_step = (mode == MODE_WCMP) ? (word_cnt + ONE) : (word_cnt - ONE);
    terminal  = 1'b0;
    case (mode)
      MODE_WCZ:  terminal = (word_step == '0);
      MODE_WCMP: terminal = (word_step == word_reg);
      MODE_ACMP: terminal = (addr_step == word_reg);
      MODE_WRAP: terminal = (word_step == '0);
      default:   terminal = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: loads return to IDLE, steps move to RUN or STOP.
  always_comb begin
    state_nxt = state;
    case (instr)
      I_WCR, I_REINIT, I_LDW: state_nxt = ST_IDLE;
      I_ENC: begin
        if (step) begin
          if (mode == MODE_WRAP) begin
            state_nxt = ST_RUN;
          end else if (terminal) begin
            state_nxt = ST_STOP;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Control, reload and counter registers updated from the instruction.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ctrl     <= '0;
      addr_reg <= '0;
      addr_cnt <= '0;
      word_reg <= '0;
      word_cnt <= '0;
    end else begin
      case (instr)
        I_WCR: ctrl <= data_in[2:0];
        I_REINIT: begin
          addr_cnt <= addr_reg;
          word_cnt <= (mode == MODE_WCMP) ? '0 : word_reg;
        end
        I_LDA: begin
          addr_reg <= data_in;
          addr_cnt <= data_in;
        end
        I_LDW: begin
          word_reg <= data_in;
          word_cnt <= (mode == MODE_WCMP) ? '0 : data_in;
        end
        I_ENC: begin
          if (step) begin
            addr_cnt <= addr_step;
            word_cnt <= word_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-cycle completion pulse for the wrapping mode.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= step && terminal && (mode == MODE_WRAP);
    end
  end

  // Read-back mux, combinational from the current instruction.
  always_comb begin
    data_out = '0;
    data_oe  = 1'b0;
    case (instr)
      I_RCR: begin
        data_out = {{(AW-3){1'b0}}, ctrl};
        data_oe  = 1'b1;
      end
      I_RWC: begin
        data_out = word_cnt;
        data_oe  = 1'b1;
      end
      I_RAC: begin
        data_out = addr_cnt;
        data_oe  = 1'b1;
      end
      default: begin
        data_out = '0;
        data_oe  = 1'b0;
      end
    endcase
  end

  assign addr_out = addr_cnt;
  assign busy     = (state == ST_RUN);
  assign done     = (mode == MODE_WRAP) ? wrap_pulse : (state == ST_STOP);

endmodule

// File: tb/tb_dma_addr_sequencer.sv
// Directed bench for dma_addr_sequencer with hand-computed expectations.
module tb_dma_addr_sequencer;

  localparam logic [2:0] WCR = 3'd0, RCR = 3'd1, RWC = 3'd2, RAC = 3'd3;
  localparam logic [2:0] REINIT = 3'd4, LDA = 3'd5, LDW = 3'd6, ENC = 3'd7;

  logic       clk;
  logic       res;
  logic [2:0] instr;
  logic [7:0] data_in;
  logic       cnt_en;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] addr_out;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  dma_addr_sequencer #(.AW(8)) dut (
    .clk(clk), .res(res), .instr(instr), .data_in(data_in), .cnt_en(cnt_en),
    .data_out(data_out), .data_oe(data_oe), .addr_out(addr_out),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction across a rising edge; outputs settle at edge+1.
  task automatic issue(input logic [2:0] i, input logic [7:0] d, input logic e);
    @(negedge clk);
    instr = i; data_in = d; cnt_en = e;
    @(posedge clk);
    #1;
    instr = WCR; data_in = 8'h00; cnt_en = 1'b0;
    instr = 3'd1;
  endtask

  // Present a read instruction between edges (no registered effect).
  task automatic present_read(input logic [2:0] i);
    @(negedge clk);
    instr = i; cnt_en = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    res = 1'b0; instr = RCR; data_in = 8'h00; cnt_en = 1'b0;
    instr = 3'd4;
    #12;
    instr = ENC;
    #1;
    total++; if (addr_out !== 8'h00) begin bad++; $display("FAIL rst_addr: got %0h want 00", addr_out); end
    total++; if ({done, busy, data_oe} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {done, busy, data_oe}); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data: got %0h want 00", data_out); end
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic test_mode00;
    logic [7:0] exp_a [5] = '{8'h11, 8'h12, 8'h13, 8'h13, 8'h13};
    logic       exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    issue(WCR, 8'h00, 1'b0);
    issue(LDA, 8'h10, 1'b0);
    issue(LDW, 8'h03, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL m00_idle_busy: got %b want 0", busy); end
    for (int k = 0; k < 5; k++) begin
      issue(ENC, 8'h00, 1'b1);
      total++; if (addr_out !== exp_a[k]) begin bad++; $display("FAIL m00_addr%0d: got %0h want %0h", k, addr_out, exp_a[k]); end
      total++; if (done !== exp_d[k]) begin bad++; $display("FAIL m00_done%0d: got %b want %b", k, done, exp_d[k]); end
      total++; if (busy !== exp_b[k]) begin bad++; $display("FAIL m00_busy%0d: got %b want %b", k, busy, exp_b[k]); end
    end
    present_read(RWC);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL m00_wc: got %0h want 00", data_out); end
  endtask

  task automatic test_mode01_dec;
    issue(WCR, 8'h05, 1'b0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL m01_wcr_done: got %b want 0", done); end
    issue(LDA, 8'h80, 1'b0);
    issue(LDW, 8'h02, 1'b0);
    present_read(RWC);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL m01_wc0: got %0h want 00", data_out); end
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h7F) begin bad++; $display("FAIL m01_addr1: got %0h want 7f", addr_out); end
    present_read(RWC);
    total++; if (data_out !== 8'h01) begin bad++; $display("FAIL m01_wc1: got %0h want 01", data_out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL m01_done1: got %b want 0", done); end
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h7E) begin bad++; $display("FAIL m01_addr2: got %0h want 7e", addr_out); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL m01_done2: got %b want 1", done); end
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h7E) begin bad++; $display("FAIL m01_hold: got %0h want 7e", addr_out); end
    present_read(RWC);
    total++; if (data_out !== 8'h02 || data_oe !== 1'b1) begin bad++; $display("FAIL m01_rwc: got %0h/%b want 02/1", data_out, data_oe); end
  endtask

  task automatic test_mode10_wrap_addr;
    logic [7:0] exp_a [4] = '{8'hFF, 8'h00, 8'h01, 8'h01};
    logic       exp_d [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    issue(WCR, 8'h02, 1'b0);
    issue(LDA, 8'hFE, 1'b0);
    issue(LDW, 8'h01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      issue(ENC, 8'h00, 1'b1);
      total++; if (addr_out !== exp_a[k]) begin bad++; $display("FAIL m10_addr%0d: got %0h want %0h", k, addr_out, exp_a[k]); end
      total++; if (done !== exp_d[k]) begin bad++; $display("FAIL m10_done%0d: got %b want %b", k, done, exp_d[k]); end
    end
    present_read(RAC);
    total++; if (data_out !== 8'h01) begin bad++; $display("FAIL m10_rac: got %0h want 01", data_out); end
  endtask

  task automatic test_mode11_wrap;
    logic [7:0] exp_w [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    logic       exp_d [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    issue(WCR, 8'h03, 1'b0);
    issue(LDW, 8'h02, 1'b0);
    for (int k = 0; k < 4; k++) begin
      issue(ENC, 8'h00, 1'b1);
      total++; if (done !== exp_d[k]) begin bad++; $display("FAIL m11_done%0d: got %b want %b", k, done, exp_d[k]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL m11_busy%0d: got %b want 1", k, busy); end
      present_read(RWC);
      total++; if (data_out !== exp_w[k]) begin bad++; $display("FAIL m11_wc%0d: got %0h want %0h", k, data_out, exp_w[k]); end
    end
  endtask

  task automatic test_hold_and_reads;
    issue(ENC, 8'h00, 1'b0);
    issue(RAC, 8'h00, 1'b1);
    issue(RCR, 8'h00, 1'b1);
    present_read(RWC);
    total++; if (data_out !== 8'hFE) begin bad++; $display("FAIL hold_wc: got %0h want fe", data_out); end
    present_read(RAC);
    total++; if (data_out !== 8'h05) begin bad++; $display("FAIL hold_ac: got %0h want 05", data_out); end
    present_read(RCR);
    total++; if (data_out !== 8'h03 || data_oe !== 1'b1) begin bad++; $display("FAIL rcr: got %0h/%b want 03/1", data_out, data_oe); end
    present_read(LDA);
    total++; if (data_oe !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL no_read_oe: got %0h/%b want 00/0", data_out, data_oe); end
  endtask

  task automatic test_mid_reset_and_reinit;
    issue(WCR, 8'h00, 1'b0);
    issue(LDA, 8'h40, 1'b0);
    issue(LDW, 8'h05, 1'b0);
    issue(ENC, 8'h00, 1'b1);
    issue(LDA, 8'h90, 1'b0);
    total++; if (addr_out !== 8'h90 || busy !== 1'b1) begin bad++; $display("FAIL lda_run: got %0h/%b want 90/1", addr_out, busy); end
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h91) begin bad++; $display("FAIL lda_run_step: got %0h want 91", addr_out); end
    #2;
    instr = ENC;
    res = 1'b0;
    #1;
    total++; if (addr_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst: got %0h/%b/%b want 00/0/0", addr_out, busy, done); end
    @(negedge clk);
    res = 1'b1;
    present_read(RWC);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_wc: got %0h want 00", data_out); end
    issue(LDA, 8'h20, 1'b0);
    issue(LDW, 8'h01, 1'b0);
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h21 || done !== 1'b1) begin bad++; $display("FAIL reinit_pre: got %0h/%b want 21/1", addr_out, done); end
    issue(REINIT, 8'h00, 1'b0);
    total++; if (addr_out !== 8'h20 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reinit: got %0h/%b/%b want 20/0/0", addr_out, done, busy); end
    present_read(RWC);
    total++; if (data_out !== 8'h01) begin bad++; $display("FAIL reinit_wc: got %0h want 01", data_out); end
  endtask

  task automatic test_zero_start;
    issue(WCR, 8'h00, 1'b0);
    issue(LDA, 8'h00, 1'b0);
    issue(LDW, 8'h00, 1'b0);
    for (int k = 0; k < 255; k++) issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'hFF || done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zs_255: got %0h/%b/%b want ff/0/1", addr_out, done, busy); end
    issue(ENC, 8'h00, 1'b1);
    total++; if (addr_out !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zs_256: got %0h/%b/%b want 00/1/0", addr_out, done, busy); end
  endtask

  initial begin
    test_reset;
    test_mode00;
    test_mode01_dec;
    test_mode10_wrap_addr;
    test_mode11_wrap;
    test_hold_and_reads;
    test_mid_reset_and_reinit;
    test_zero_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
